// File: rtl/band_readout_if.sv
// band_readout_if
//   Bundles the readout sequencer's frame trigger, band-mux connection and
//   byte-stream handshake.
//   frame_ready : start-of-frame pulse from the extractor
//   mux_data    : 12-bit band value returned by the band mux for `select`
//   out_ready   : byte consumer accepts out_byte this cycle
//   select      : band index driven to the mux
//   out_byte    : streamed byte (0 while out_valid is low)
//   out_valid   : out_byte holds a valid byte
//   busy        : frame readout in progress
//   frame_done  : one-cycle pulse after the last byte of a frame is taken
//   overrun     : sticky flag, frame_ready seen while busy
//   modport master : the sequencer side
//   modport slave  : the environment side (extractor, mux, consumer)
interface band_readout_if;
   logic        frame_ready;
   logic [11:0] mux_data;
   logic        out_ready;
   logic [3:0]  select;
   logic [7:0]  out_byte;
   logic        out_valid;
   logic        busy;
   logic        frame_done;
   logic        overrun;

   modport master (
      input  frame_ready, mux_data, out_ready,
      output select, out_byte, out_valid, busy, frame_done, overrun
   );

   modport slave (
      output frame_ready, mux_data, out_ready,
      input  select, out_byte, out_valid, busy, frame_done, overrun
   );
endinterface

// File: rtl/band_readout_sequencer.sv
// band_readout_sequencer
//   On each frame_ready pulse, walks the band-mux select through bands
//   0..N_BANDS-1, captures each 12-bit band value and streams it as two
//   bytes ({band, value[11:8]} then value[7:0]) over a valid/ready byte port.
//   Parameters : N_BANDS (2..16) bands read per frame
//   Ports      : clk, rst (async, active high), bus (band_readout_if.master)
//   All outputs come from registers or FSM state; none depend
//   combinationally on out_ready or mux_data.
module band_readout_sequencer #(
   parameter int unsigned N_BANDS = 16
) (
   input  logic           clk,
   input  logic           rst,
   band_readout_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      LATCH,
      HI,
      LO
   } state_e;

   localparam logic [3:0] LAST_BAND = 4'(N_BANDS - 1);

   state_e      state_q, state_d;
   logic [3:0]  band_q, band_d;
   logic [11:0] hold_q, hold_d;
   logic        frame_done_q, frame_done_d;
   logic        overrun_q, overrun_d;

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         band_q       <= '0;
         hold_q       <= '0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         band_q       <= band_d;
         hold_q       <= hold_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path
      // leaves it unassigned, which would infer a latch.
      state_d      = state_q;
      band_d       = band_q;
      hold_d       = hold_q;
      frame_done_d = 1'b0;
      // A frame request outside IDLE, including the LO->IDLE edge itself,
      // is dropped but remembered until reset.
      overrun_d    = overrun_q | (bus.frame_ready && (state_q != IDLE));

      case (state_q)
         IDLE: begin
            if (bus.frame_ready) begin
               state_d = LATCH;
               band_d  = '0;
            end
         end
         LATCH: begin
            // select has been stable since the previous edge, so the mux
            // output is settled for this band.
            hold_d  = bus.mux_data;
            state_d = HI;
         end
         HI: begin
            if (bus.out_ready) state_d = LO;
         end
         LO: begin
            if (bus.out_ready) begin
               if (band_q == LAST_BAND) begin
                  state_d      = IDLE;
                  band_d       = '0;
                  frame_done_d = 1'b1;
               end else begin
                  state_d = LATCH;
                  band_d  = band_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic, decoded from registered state only.
   always_comb begin
      bus.select     = band_q;
      bus.out_valid  = (state_q == HI) || (state_q == LO);
      bus.busy       = (state_q != IDLE);
      bus.frame_done = frame_done_q;
      bus.overrun    = overrun_q;
      case (state_q)
         HI:      bus.out_byte = {band_q, hold_q[11:8]};
         LO:      bus.out_byte = hold_q[7:0];
         default: bus.out_byte = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_band_readout_sequencer.sv
// tb_band_readout_sequencer
//   Drives a 16-band and a 4-band sequencer from one directed initial block.
//   The band mux is modelled as a lookup table; the expected byte stream of a
//   frame is built directly from the table, and accepted bytes are collected
//   on every valid/ready cycle and compared in order.
module tb_band_readout_sequencer;

   logic clk;
   logic rst;
   logic fr;
   logic rdy;
   logic use4;

   logic [11:0] mem [16];

   band_readout_if bus16 ();
   band_readout_if bus4 ();

   band_readout_sequencer #(.N_BANDS(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
   band_readout_sequencer #(.N_BANDS(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

   assign bus16.frame_ready = fr & ~use4;
   assign bus4.frame_ready  = fr & use4;
   assign bus16.out_ready   = rdy & ~use4;
   assign bus4.out_ready    = rdy & use4;
   assign bus16.mux_data    = mem[bus16.select];
   assign bus4.mux_data     = mem[bus4.select];

   logic       t_valid, t_busy, t_done, t_ovr;
   logic [7:0] t_byte;
   logic [3:0] t_sel;
   assign t_valid = use4 ? bus4.out_valid  : bus16.out_valid;
   assign t_busy  = use4 ? bus4.busy       : bus16.busy;
   assign t_done  = use4 ? bus4.frame_done : bus16.frame_done;
   assign t_ovr   = use4 ? bus4.overrun    : bus16.overrun;
   assign t_byte  = use4 ? bus4.out_byte   : bus16.out_byte;
   assign t_sel   = use4 ? bus4.select     : bus16.select;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;
   int cyc_cnt = 0;
   logic exp_ovr [2];
   logic [7:0] exp_q [$];
   logic [7:0] got_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      cyc_cnt++;
   endtask

   // One frame on the selected DUT.
   //   stall_at/stall_len : hold out_ready low for stall_len cycles in HI of that band
   //   ovr_at             : band whose HI gets a second frame_ready; ovr_at==nb
   //                        means on the final LO handshake
   //   abort_at           : band whose LO gets an asynchronous reset
   task automatic run_frame(input bit four, input int stall_at, input int stall_len,
                            input int ovr_at, input int abort_at, input bit rnd_rdy,
                            input bit chk_timing);
      int   nb;
      int   t0, td, stalled;
      logic [7:0] held;
      bit   injected, just_inj, done;
      nb = four ? 4 : 16;
      use4 = four;
      exp_q = {};
      got_q = {};
      for (int i = 0; i < nb; i++) begin
         exp_q.push_back({4'(i), mem[i][11:8]});
         exp_q.push_back(mem[i][7:0]);
      end

      fr = 1'b1;
      cyc();
      fr = 1'b0;
      check("latch_busy", t_busy, 1);
      check("latch_valid", t_valid, 0);
      t0 = cyc_cnt;
      td = 0;
      done = 0;
      stalled = 0;
      injected = 0;
      held = 8'h00;

      for (int c = 0; c < 600 && !done; c++) begin
         rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         just_inj = 0;
         if (t_valid) check("sel_track", t_sel, got_q.size() / 2);
         else         check("byte_zero", t_byte, 0);
         check("sel_range", t_sel < nb, 1);

         if (t_valid && got_q.size() == 2 * stall_at && stalled < stall_len) begin
            rdy = 1'b0;
            if (stalled == 0) begin
               held = t_byte;
               check("stall_hi", t_byte, {4'(stall_at), mem[stall_at][11:8]});
            end else begin
               check("stall_hold", t_byte, held);
            end
            check("stall_sel", t_sel, stall_at);
            stalled++;
         end

         if (ovr_at >= 0 && !injected && t_valid &&
             ((ovr_at < nb && got_q.size() == 2 * ovr_at) ||
              (ovr_at == nb && got_q.size() == 2 * nb - 1 && rdy))) begin
            fr = 1'b1;
            injected = 1;
            just_inj = 1;
            exp_ovr[four] = 1'b1;
         end

         if (abort_at >= 0 && t_valid && got_q.size() == 2 * abort_at + 1) begin
            rdy = 1'b0;
            #2 rst = 1'b1;
            #1;
            check("abort_valid", t_valid, 0);
            check("abort_sel", t_sel, 0);
            check("abort_busy", t_busy, 0);
            check("abort_byte", t_byte, 0);
            check("abort_ovr", t_ovr, 0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            cyc_cnt++;
            exp_ovr[0] = 1'b0;
            exp_ovr[1] = 1'b0;
            check("abort_idle", t_busy, 0);
            return;
         end

         if (t_valid && rdy) got_q.push_back(t_byte);
         cyc();
         fr = 1'b0;
         if (just_inj) check("overrun_set", t_ovr, 1);
         if (t_done) begin
            done = 1;
            td = cyc_cnt;
         end
      end

      check("frame_done_seen", done, 1);
      if (chk_timing) check("frame_len", td - t0, 3 * nb);
      check("idle_busy", t_busy, 0);
      check("idle_sel", t_sel, 0);
      check("byte_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i < got_q.size()) check($sformatf("byte%0d", i), got_q[i], exp_q[i]);
      check("overrun_flag", t_ovr, exp_ovr[four]);
      cyc();
      check("done_pulse", t_done, 0);
      check("no_restart", t_busy, 0);
   endtask

   task automatic fill_random();
      for (int i = 0; i < 16; i++) mem[i] = 12'($urandom);
   endtask

   initial begin
      rst = 1'b1;
      fr = 1'b0;
      rdy = 1'b0;
      use4 = 1'b0;
      exp_ovr[0] = 1'b0;
      exp_ovr[1] = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 12'h100 + 12'(i);

      // Reset applied before any clock edge.
      #3;
      check("rst_valid16", bus16.out_valid, 0);
      check("rst_byte16", bus16.out_byte, 0);
      check("rst_sel16", bus16.select, 0);
      check("rst_busy16", bus16.busy, 0);
      check("rst_done16", bus16.frame_done, 0);
      check("rst_ovr16", bus16.overrun, 0);
      check("rst_valid4", bus4.out_valid, 0);
      check("rst_sel4", bus4.select, 0);
      cyc();
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("idle_valid", bus16.out_valid, 0);
         check("idle_sel0", bus16.select, 0);
         check("idle_busy0", bus16.busy, 0);
         check("idle_byte0", bus16.out_byte, 0);
      end

      // Full 16-band frame, out_ready high, band i = 12'h100 + i.
      run_frame(0, -1, 0, -1, -1, 0, 1);

      // Backpressure in HI of band 3.
      fill_random();
      mem[3] = 12'hABC;
      run_frame(0, 3, 5, -1, -1, 0, 0);

      // Second frame_ready during band 7: frame completes, overrun sticks.
      fill_random();
      run_frame(0, -1, 0, 7, -1, 0, 1);

      // Random backpressure frames; overrun stays set.
      fill_random();
      run_frame(0, -1, 0, -1, -1, 1, 0);
      fill_random();
      run_frame(0, 5, 3, -1, -1, 1, 0);

      // Four-band instance: plain frame, then frame_ready on the final handshake.
      fill_random();
      run_frame(1, -1, 0, -1, -1, 0, 1);
      fill_random();
      run_frame(1, -1, 0, 4, -1, 0, 1);
      fill_random();
      run_frame(1, -1, 0, -1, -1, 1, 0);

      // Reset during LO of band 9, then a fresh frame from band 0.
      fill_random();
      run_frame(0, -1, 0, -1, 9, 0, 0);
      check("post_abort_ovr4", bus4.overrun, 0);
      fill_random();
      run_frame(0, -1, 0, -1, -1, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
